// File: rtl/rambit_clr_pkg.sv
// rambit_clr_pkg
//   Shared sizing helpers for the rambit_clr RAM and its clear sequencer.
//   No ports; imported by rambit_clr and rambit_clr_seq.
package rambit_clr_pkg;

   // Data bits covered by one write-mask bit.
   function automatic int unsigned lane_width(input int unsigned dw, input int unsigned mw);
      return dw / mw;
   endfunction

   // Number of words addressed by an aw-bit address.
   function automatic int unsigned mem_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/rambit_clr_seq.sv
// rambit_clr_seq
//   Clear sequencer for rambit_clr: a two-state FSM (CLEAR/READY) plus the sweep
//   counter. In CLEAR it presents one sweep write per cycle, walking addresses
//   0 .. 2**AW-1 exactly once, then settles in READY until clr is pulsed.
// Ports
//   clk    in   clock
//   nreset in   asynchronous active-low reset (re-enters CLEAR at address 0)
//   clr    in   restart the sweep at address 0
//   busy   out  sweep in progress
//   swe    out  sweep write enable for the array
//   saddr  out  sweep write address
module rambit_clr_seq
   import rambit_clr_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          clr,
   output logic          busy,
   output logic          swe,
   output logic [AW-1:0] saddr
);

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_READY = 1'b1;

   // Explicit last-address compare keeps the counter at AW bits without wrapping.
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   logic          state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end else if (state_q == ST_CLEAR) begin
         if (cnt_q == LAST_ADDR) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy  = (state_q == ST_CLEAR);
   // A sweep write during a clr cycle only rewrites INITVAL; the restart covers it.
   assign swe   = (state_q == ST_CLEAR);
   assign saddr = cnt_q;

endmodule

// File: rtl/rambit_clr.sv
// rambit_clr
//   Single-port synchronous RAM with per-lane write mask, optional output
//   register and a built-in clear sweep that fills every word with INITVAL
//   after reset or on a clr pulse. Reads are read-first.
// Ports
//   clk    in   clock
//   nreset in   asynchronous active-low reset (control/output regs only)
//   ce     in   start one read (plus masked write) access
//   we     in   write mask, bit k covers din[k*DW/MW +: DW/MW]
//   addr   in   access address
//   din    in   write data
//   clr    in   restart the clear sweep; drops a same-cycle access
//   busy   out  clear sweep in progress, accesses ignored
//   dout   out  read data, held while dvalid is low
//   dvalid out  one-cycle strobe for new dout (latency 1, or 2 with RDREG)
module rambit_clr
   import rambit_clr_pkg::*;
#(
   parameter int unsigned    DW      = 16,
   parameter int unsigned    AW      = 10,
   parameter int unsigned    MW      = 16,
   parameter int unsigned    RDREG   = 0,
   parameter logic [DW-1:0]  INITVAL = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          ce,
   input  logic [MW-1:0] we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   input  logic          clr,
   output logic          busy,
   output logic [DW-1:0] dout,
   output logic          dvalid
);

   localparam int unsigned LW    = lane_width(DW, MW);
   localparam int unsigned DEPTH = mem_depth(AW);

   logic [DW-1:0] ram [DEPTH];

   logic          swe;
   logic [AW-1:0] saddr;

   rambit_clr_seq #(
      .AW (AW)
   ) u_seq (
      .clk    (clk),
      .nreset (nreset),
      .clr    (clr),
      .busy   (busy),
      .swe    (swe),
      .saddr  (saddr)
   );

   // clr has priority over a same-cycle user access.
   logic acc;
   assign acc = ce & ~busy & ~clr;

   logic [MW-1:0] wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   always_comb begin
      wen   = '0;
      waddr = addr;
      wdata = din;
      if (swe) begin
         wen   = '1;
         waddr = saddr;
         wdata = INITVAL;
      end else if (acc) begin
         wen = we;
      end
   end

   // Array is intentionally not reset; the sweep gives it a known state.
   always_ff @(posedge clk) begin
      for (int k = 0; k < MW; k++) begin
         if (wen[k]) begin
            ram[waddr][k*LW +: LW] <= wdata[k*LW +: LW];
         end
      end
   end

   // First read stage; nonblocking read of ram gives read-first behaviour.
   logic [DW-1:0] rd1_q;
   logic          rv1_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rd1_q <= '0;
         rv1_q <= 1'b0;
      end else begin
         rv1_q <= acc;
         if (acc) begin
            rd1_q <= ram[addr];
         end
      end
   end

   if (RDREG != 0) begin : g_rdreg
      logic [DW-1:0] rd2_q;
      logic          rv2_q;

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            rd2_q <= '0;
            rv2_q <= 1'b0;
         end else begin
            rv2_q <= rv1_q;
            if (rv1_q) begin
               rd2_q <= rd1_q;
            end
         end
      end

      assign dout   = rd2_q;
      assign dvalid = rv2_q;
   end else begin : g_noreg
      assign dout   = rd1_q;
      assign dvalid = rv1_q;
   end

endmodule

// File: tb/tb_rambit_clr.sv
// tb_rambit_clr
//   Self-checking bench: two instances (RDREG=0 and RDREG=1) share one stimulus
//   stream. A word-array reference model predicts busy, dout and dvalid; a
//   constant vector table and hand-written sequences cover the corner cases.
module tb_rambit_clr;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned MW    = 2;
   localparam int unsigned LW    = DW / MW;
   localparam int unsigned DEPTH = 16;
   localparam logic [DW-1:0] INITVAL = 16'h0000;

   logic          clk    = 1'b0;
   logic          nreset = 1'b1;
   logic          ce     = 1'b0;
   logic          clr    = 1'b0;
   logic [MW-1:0] we     = '0;
   logic [AW-1:0] addr   = '0;
   logic [DW-1:0] din    = '0;

   logic          busy0, busy1, dvalid0, dvalid1;
   logic [DW-1:0] dout0, dout1;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [DW-1:0] m_mem [DEPTH];
   int            sweep_left = 0;
   logic          e_v0 = 1'b0, e_v1 = 1'b0;
   logic [DW-1:0] e_d0 = '0, e_d1 = '0;

   typedef struct {
      logic          ce;
      logic [1:0]    we;
      logic [3:0]    addr;
      logic [15:0]   din;
      logic          clr;
      logic [15:0]   d0;
      logic          v0;
      logic [15:0]   d1;
      logic          v1;
   } vec_t;

   vec_t tbl [15];

   rambit_clr #(
      .DW (DW), .AW (AW), .MW (MW), .RDREG (0), .INITVAL (INITVAL)
   ) u_dut0 (
      .clk (clk), .nreset (nreset), .ce (ce), .we (we), .addr (addr), .din (din),
      .clr (clr), .busy (busy0), .dout (dout0), .dvalid (dvalid0)
   );

   rambit_clr #(
      .DW (DW), .AW (AW), .MW (MW), .RDREG (1), .INITVAL (INITVAL)
   ) u_dut1 (
      .clk (clk), .nreset (nreset), .ce (ce), .we (we), .addr (addr), .din (din),
      .clr (clr), .busy (busy1), .dout (dout1), .dvalid (dvalid1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_fill();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = INITVAL;
   endtask

   // One clock edge of the specified behaviour, applied to the current inputs.
   task automatic model_step();
      logic          accepted;
      logic [DW-1:0] rd;
      accepted = ce && (sweep_left == 0) && !clr;
      rd = m_mem[addr];
      if (accepted) begin
         for (int k = 0; k < MW; k++)
            if (we[k]) m_mem[addr][k*LW +: LW] = din[k*LW +: LW];
      end
      // Two-cycle instance reports last cycle's result.
      e_v1 = e_v0;
      if (e_v0) e_d1 = e_d0;
      e_v0 = accepted;
      if (accepted) e_d0 = rd;
      // The sweep leaves every word at INITVAL and nothing can be read meanwhile.
      if (clr) begin
         sweep_left = DEPTH;
         model_fill();
      end else if (sweep_left > 0) begin
         sweep_left--;
      end
   endtask

   task automatic check_model();
      chk("busy0", 16'(busy0), 16'(sweep_left > 0));
      chk("busy1", 16'(busy1), 16'(sweep_left > 0));
      chk("dout0", dout0, e_d0);
      chk("dvalid0", 16'(dvalid0), 16'(e_v0));
      chk("dout1", dout1, e_d1);
      chk("dvalid1", 16'(dvalid1), 16'(e_v1));
   endtask

   task automatic cycle(input logic c, input logic [1:0] w, input logic [3:0] a,
                        input logic [15:0] d, input logic cl);
      ce = c; we = w; addr = a; din = d; clr = cl;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
   endtask

   // Assert reset away from a clock edge, hold over `hold` edges, release on negedge.
   task automatic reset_pulse(input int hold);
      nreset = 1'b0;
      #1;
      e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
      sweep_left = DEPTH;
      chk("rst_dout0", dout0, 16'h0000);
      chk("rst_dvalid0", 16'(dvalid0), 16'h0000);
      chk("rst_dout1", dout1, 16'h0000);
      chk("rst_dvalid1", 16'(dvalid1), 16'h0000);
      chk("rst_busy0", 16'(busy0), 16'h0001);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_model();
      end
      @(negedge clk);
      nreset = 1'b1;
      model_fill();
      sweep_left = DEPTH;
   endtask

   initial begin
      //            ce  we     addr   din       clr   d0        v0    d1        v1
      tbl[0]  = '{1'b1, 2'b10, 4'd3, 16'hABCD, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 2'b00, 4'd3, 16'h0000, 1'b0, 16'hAB00, 1'b1, 16'h0000, 1'b1};
      tbl[2]  = '{1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 16'h0000, 1'b1, 16'hAB00, 1'b1};
      tbl[3]  = '{1'b1, 2'b11, 4'd5, 16'h2222, 1'b0, 16'h1111, 1'b1, 16'h0000, 1'b1};
      tbl[4]  = '{1'b1, 2'b00, 4'd5, 16'h0000, 1'b0, 16'h2222, 1'b1, 16'h1111, 1'b1};
      tbl[5]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h2222, 1'b0, 16'h2222, 1'b1};
      tbl[6]  = '{1'b1, 2'b11, 4'd0, 16'h0A0A, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0};
      tbl[7]  = '{1'b1, 2'b11, 4'd1, 16'h1B1B, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1};
      tbl[8]  = '{1'b1, 2'b11, 4'd2, 16'h2C2C, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1};
      tbl[9]  = '{1'b1, 2'b01, 4'd2, 16'hFFEE, 1'b0, 16'h2C2C, 1'b1, 16'h0000, 1'b1};
      tbl[10] = '{1'b1, 2'b00, 4'd0, 16'h0000, 1'b0, 16'h0A0A, 1'b1, 16'h2C2C, 1'b1};
      tbl[11] = '{1'b1, 2'b00, 4'd1, 16'h0000, 1'b0, 16'h1B1B, 1'b1, 16'h0A0A, 1'b1};
      tbl[12] = '{1'b1, 2'b00, 4'd2, 16'h0000, 1'b0, 16'h2CEE, 1'b1, 16'h1B1B, 1'b1};
      tbl[13] = '{1'b1, 2'b00, 4'd3, 16'h0000, 1'b0, 16'hAB00, 1'b1, 16'h2CEE, 1'b1};
      tbl[14] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 16'hAB00, 1'b0, 16'hAB00, 1'b1};

      #2;
      reset_pulse(2);
      // Initial sweep: busy for exactly DEPTH edges.
      idle(DEPTH);

      // Table starts on the first busy=0 cycle.
      for (int i = 0; i < 15; i++) begin
         cycle(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].clr);
         chk("tbl_dout0", dout0, tbl[i].d0);
         chk("tbl_dvalid0", 16'(dvalid0), 16'(tbl[i].v0));
         chk("tbl_dout1", dout1, tbl[i].d1);
         chk("tbl_dvalid1", 16'(dvalid1), 16'(tbl[i].v1));
      end

      // clr with a same-cycle full write to 7; the previous read still completes.
      cycle(1'b1, 2'b11, 4'd7, 16'h7777, 1'b0);
      cycle(1'b1, 2'b00, 4'd3, 16'h0000, 1'b0);
      cycle(1'b1, 2'b11, 4'd7, 16'hFFFF, 1'b1);
      chk("clr_dvalid0", 16'(dvalid0), 16'h0000);
      chk("clr_prev_dvalid1", 16'(dvalid1), 16'h0001);
      chk("clr_prev_dout1", dout1, 16'hAB00);
      chk("clr_busy0", 16'(busy0), 16'h0001);
      idle(DEPTH);
      cycle(1'b1, 2'b00, 4'd7, 16'h0000, 1'b0);
      chk("clr_word7", dout0, INITVAL);
      chk("clr_word7_dvalid", 16'(dvalid0), 16'h0001);
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 2'b00, 4'(a), 16'h0000, 1'b0);
      idle(2);

      // Reset at sweep count 9; word 9 is only cleared by the restarted sweep.
      cycle(1'b1, 2'b11, 4'd9, 16'h9999, 1'b0);
      cycle(1'b1, 2'b00, 4'd9, 16'h0000, 1'b0);
      idle(1);
      cycle(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
      idle(9);
      chk("sweep_hold_dout0", dout0, 16'h9999);
      chk("sweep_hold_dout1", dout1, 16'h9999);
      reset_pulse(1);
      idle(DEPTH);
      cycle(1'b1, 2'b00, 4'd9, 16'h0000, 1'b0);
      chk("rst_word9", dout0, INITVAL);

      // Read in flight in the two-cycle instance is dropped by reset.
      cycle(1'b1, 2'b11, 4'd4, 16'h4444, 1'b0);
      cycle(1'b1, 2'b00, 4'd4, 16'h0000, 1'b0);
      chk("inflight_dout0", dout0, 16'h4444);
      #2;
      reset_pulse(0);
      idle(DEPTH);
      chk("inflight_dvalid1", 16'(dvalid1), 16'h0000);

      // Randomized traffic with occasional clr.
      for (int i = 0; i < 400; i++) begin
         logic          rc, rcl;
         logic [1:0]    rw;
         logic [3:0]    ra;
         logic [15:0]   rd;
         rc  = ($urandom_range(0, 9) < 7);
         rcl = ($urandom_range(0, 39) == 0);
         rw  = 2'($urandom);
         ra  = 4'($urandom);
         rd  = 16'($urandom);
         cycle(rc, rw, ra, rd, rcl);
      end
      idle(DEPTH + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
